mem_port_arbiter: RTL and testbench

- Shares a single physical memory port between the fetch stage (I-side, read-only) and the memory stage (D-side, read/write) of the pipelined LC-3b.
- Latches the winning request, drives the physical port until the memory responds, then returns the one-cycle response to the winning requester.
- Alternates grants fairly when both sides contend.
- Sits between the pipeline stages and the physical memory (or the next cache level).

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch-side, memory-stage-side and physical memory port signals
// around the arbiter. The slave modport is the arbiter's view of the bundle.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = 2
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [MASK_W-1:0] d_wmask;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [MASK_W-1:0] pmem_wmask;
  logic [ADDR_W-1:0] pmem_address;
  logic [DATA_W-1:0] pmem_wdata;
  logic [DATA_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_wmask, d_addr, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_wmask, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between LC-3b fetch (read-only) and the
// memory stage (read/write), alternating grants under contention.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = 2
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              last_grant;   // 0 = I-side, 1 = D-side
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [MASK_W-1:0] lat_wmask;

  logic i_req, d_req;
  logic grant_i, grant_d, done;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          grant_i = last_grant;
          grant_d = ~last_grant;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
        if (grant_i)      state_next = SERVE_I;
        else if (grant_d) state_next = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        lat_write <= 1'b0;
        lat_addr  <= bus.i_addr;
        lat_wdata <= '0;
        lat_wmask <= '0;
      end else if (grant_d) begin
        // A simultaneous read+write from the D-side is resolved as a write.
        lat_write <= bus.d_write;
        lat_addr  <= bus.d_addr;
        lat_wdata <= bus.d_wdata;
        lat_wmask <= bus.d_write ? bus.d_wmask : '0;
      end
      if (done) last_grant <= (state == SERVE_D);
    end
  end

  logic serving;
  assign serving = (state == SERVE_I) || (state == SERVE_D);

  assign bus.pmem_read    = serving & ~lat_write;
  assign bus.pmem_write   = serving &  lat_write;
  assign bus.pmem_address = lat_addr;
  assign bus.pmem_wdata   = lat_wdata;
  assign bus.pmem_wmask   = lat_wmask;

  assign bus.i_resp  = (state == SERVE_I) & bus.pmem_resp;
  assign bus.d_resp  = (state == SERVE_D) & bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after each
// rising edge, outputs are checked 1 unit later.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16), .MASK_W(2)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " pmem_read"},  bus.pmem_read,  1'b0);
    chk({tag, " pmem_write"}, bus.pmem_write, 1'b0);
    chk({tag, " i_resp"},     bus.i_resp,     1'b0);
    chk({tag, " d_resp"},     bus.d_resp,     1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.i_read = 0; bus.i_addr = 0;
    bus.d_read = 0; bus.d_write = 0; bus.d_wmask = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.pmem_rdata = 0; bus.pmem_resp = 0;

    // Reset state
    next_cycle();
    next_cycle();
    settle();
    chk_quiet("reset");
    chk("reset pmem_address", bus.pmem_address, 16'h0000);
    chk("reset pmem_wdata",   bus.pmem_wdata,   16'h0000);
    chk("reset pmem_wmask",   bus.pmem_wmask,   2'b00);
    reset = 1'b0;

    // Single fetch, memory responds in the third serve cycle
    next_cycle();
    bus.i_read = 1; bus.i_addr = 16'h1000;
    settle();
    chk("fetch c0 pmem_read", bus.pmem_read, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 3) begin bus.pmem_resp = 1; bus.pmem_rdata = 16'h1234; end
      settle();
      chk("fetch pmem_read",    bus.pmem_read,    1'b1);
      chk("fetch pmem_address", bus.pmem_address, 16'h1000);
      chk("fetch i_resp",       bus.i_resp,       (c == 3));
      chk("fetch d_resp",       bus.d_resp,       1'b0);
    end
    chk("fetch i_rdata", bus.i_rdata, 16'h1234);
    bus.i_read = 0;
    next_cycle();
    bus.pmem_resp = 0;
    settle();
    chk_quiet("fetch bubble");

    // D-side write
    bus.d_write = 1; bus.d_addr = 16'h2002; bus.d_wdata = 16'hBEEF; bus.d_wmask = 2'b10;
    settle();
    chk("dwr c0 pmem_write", bus.pmem_write, 1'b0);
    next_cycle();
    settle();
    chk("dwr pmem_write",   bus.pmem_write,   1'b1);
    chk("dwr pmem_read",    bus.pmem_read,    1'b0);
    chk("dwr pmem_address", bus.pmem_address, 16'h2002);
    chk("dwr pmem_wdata",   bus.pmem_wdata,   16'hBEEF);
    chk("dwr pmem_wmask",   bus.pmem_wmask,   2'b10);
    chk("dwr d_resp early", bus.d_resp,       1'b0);
    next_cycle();
    bus.pmem_resp = 1;
    settle();
    chk("dwr d_resp",  bus.d_resp, 1'b1);
    chk("dwr i_resp",  bus.i_resp, 1'b0);
    bus.d_write = 0;
    next_cycle();
    bus.pmem_resp = 0;
    settle();
    chk_quiet("dwr after");

    // Contention after reset: expect D, I, D, I with an IDLE bubble each time
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.i_read = 1; bus.i_addr = 16'h1100;
    bus.d_read = 1; bus.d_addr = 16'h2200; bus.d_wmask = 2'b11; bus.d_wdata = 16'h5555;
    settle();
    for (int k = 0; k < 4; k++) begin
      automatic bit exp_d = (k % 2 == 0);
      chk("cont idle pmem_read", bus.pmem_read, 1'b0);
      next_cycle();
      settle();
      chk("cont pmem_read",    bus.pmem_read,    1'b1);
      chk("cont pmem_address", bus.pmem_address, exp_d ? 16'h2200 : 16'h1100);
      chk("cont pmem_wmask",   bus.pmem_wmask,   2'b00);
      next_cycle();
      bus.pmem_resp = 1; bus.pmem_rdata = 16'hA000 + 16'(k);
      settle();
      chk("cont d_resp", bus.d_resp, exp_d);
      chk("cont i_resp", bus.i_resp, !exp_d);
      chk("cont rdata",  exp_d ? bus.d_rdata : bus.i_rdata, 16'hA000 + 16'(k));
      next_cycle();
      bus.pmem_resp = 0;
      settle();
    end
    bus.i_read = 0; bus.d_read = 0;
    next_cycle();
    settle();
    chk_quiet("cont done");

    // Fetch request dropped mid-transaction
    bus.i_read = 1; bus.i_addr = 16'h1000;
    next_cycle();
    settle();
    chk("drop c1 pmem_address", bus.pmem_address, 16'h1000);
    next_cycle();
    bus.i_read = 0; bus.i_addr = 16'h3000;
    settle();
    chk("drop c2 pmem_read",    bus.pmem_read,    1'b1);
    chk("drop c2 pmem_address", bus.pmem_address, 16'h1000);
    next_cycle();
    bus.pmem_resp = 1;
    settle();
    chk("drop c3 pmem_address", bus.pmem_address, 16'h1000);
    chk("drop i_resp",          bus.i_resp,       1'b1);
    next_cycle();
    bus.pmem_resp = 0;
    settle();
    chk_quiet("drop after");

    // Reset in the middle of a D-side read
    bus.d_read = 1; bus.d_addr = 16'h4444;
    next_cycle();
    settle();
    chk("rst serve pmem_read", bus.pmem_read, 1'b1);
    reset = 1'b1; bus.d_read = 0;
    next_cycle();
    reset = 1'b0; bus.pmem_resp = 1;
    settle();
    chk_quiet("rst mid");
    chk("rst mid pmem_address", bus.pmem_address, 16'h0000);
    chk("rst mid pmem_wmask",   bus.pmem_wmask,   2'b00);
    chk("rst mid pmem_wdata",   bus.pmem_wdata,   16'h0000);
    next_cycle();
    bus.pmem_resp = 0;
    settle();
    chk_quiet("rst after");

    // Stray pmem_resp while idle
    bus.pmem_resp = 1;
    settle();
    chk_quiet("stray");
    next_cycle();
    bus.pmem_resp = 0;
    settle();
    chk_quiet("stray after");

    // Still idle: a new D read is served one cycle later
    bus.d_read = 1; bus.d_addr = 16'h0ABC;
    next_cycle();
    bus.d_read = 0;
    settle();
    chk("post pmem_read",    bus.pmem_read,    1'b1);
    chk("post pmem_address", bus.pmem_address, 16'h0ABC);
    next_cycle();
    bus.pmem_resp = 1;
    settle();
    chk("post d_resp", bus.d_resp, 1'b1);
    next_cycle();
    bus.pmem_resp = 0;
    settle();
    chk_quiet("post after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
